// File: rtl/matvec_pkg.sv
// Shared types and default sizing for the matrix-vector multiply engine.
package matvec_pkg;

    localparam int N_DEF    = 8;
    localparam int DW_DEF   = 8;
    localparam int ACCW_DEF = 24;
    localparam int AW_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        EXEC = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/matvec_engine_mac.sv
// One multiply-accumulate lane; acc presents the running sum including this cycle's product.
module mac_unit
    import matvec_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic            CLOCK_50,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] acc
);

    logic [2*DW-1:0] prod_s;
    logic [ACCW-1:0] prod_ext_s;
    logic [ACCW-1:0] acc_r;

    assign prod_s     = a * b;
    // Zero-extend or truncate the full product; the sum wraps modulo 2^ACCW.
    assign prod_ext_s = ACCW'(prod_s);

    // Accumulator register: cleared at the start of every run.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= acc_r + prod_ext_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = en ? (acc_r + prod_ext_s) : acc_r;

endmodule

// File: rtl/matvec_engine.sv
// N x N matrix by N-vector engine: fetches B then A rows over a read port, then runs N MAC lanes for N cycles.
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     mem_address,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic [N*DW-1:0]   mem_readdata,
    input  logic              mem_readdatavalid,
    output logic [N*ACCW-1:0] result
);

    localparam int RW = $clog2(N + 1);
    localparam int CW = $clog2(N);

    state_t              state_r;
    state_t              state_next_s;
    logic [RW-1:0]       row_r;
    logic [RW-1:0]       row_next_s;
    logic [CW-1:0]       col_r;
    logic [CW-1:0]       col_next_s;
    logic                clr_s;
    logic                en_s;
    logic                cap_s;
    logic                last_s;

    logic [N*DW-1:0]     a_buf_r [N];
    logic [N*DW-1:0]     b_buf_r;
    logic [DW-1:0]       a_elem_s [N];
    logic [DW-1:0]       b_elem_s;
    logic [ACCW-1:0]     acc_s [N];

    logic                busy_r;
    logic                done_r;
    logic                mem_read_r;
    logic [AW-1:0]       mem_address_r;
    logic [N*ACCW-1:0]   result_r;

    // Next-state, counter and datapath-control decode.
    always_comb begin
        state_next_s = state_r;
        row_next_s   = row_r;
        col_next_s   = col_r;
        clr_s        = 1'b0;
        en_s         = 1'b0;
        cap_s        = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = REQ;
                    row_next_s   = '0;
                    col_next_s   = '0;
                    clr_s        = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            REQ: begin
                if (!mem_waitrequest) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (mem_readdatavalid) begin
                    cap_s = 1'b1;
                    if (row_r == RW'(N)) begin
                        state_next_s = EXEC;
                        col_next_s   = '0;
                    end else begin
                        state_next_s = REQ;
                        row_next_s   = row_r + RW'(1);
                    end
                end else begin
                    state_next_s = WAIT;
                end
            end
            EXEC: begin
                en_s = 1'b1;
                if (col_r == CW'(N - 1)) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                    col_next_s   = '0;
                end else begin
                    state_next_s = EXEC;
                    col_next_s   = col_r + CW'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Column select: element col of B and of every buffered A row; element 0 sits in the MSBs.
    always_comb begin
        b_elem_s = '0;
        for (int i = 0; i < N; i++) begin
            a_elem_s[i] = '0;
        end
        for (int k = 0; k < N; k++) begin
            b_elem_s = (col_r == CW'(k)) ? b_buf_r[(N-1-k)*DW +: DW] : b_elem_s;
            for (int i = 0; i < N; i++) begin
                a_elem_s[i] = (col_r == CW'(k)) ? a_buf_r[i][(N-1-k)*DW +: DW] : a_elem_s[i];
            end
        end
    end

    // State and row/column counters.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            row_r   <= '0;
            col_r   <= '0;
        end else begin
            state_r <= state_next_s;
            row_r   <= row_next_s;
            col_r   <= col_next_s;
        end
    end

    // Operand buffers: word 0 is B, word r is A row r-1.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            b_buf_r <= '0;
            for (int r = 0; r < N; r++) begin
                a_buf_r[r] <= '0;
            end
        end else if (cap_s) begin
            if (row_r == RW'(0)) begin
                b_buf_r <= mem_readdata;
            end else begin
                b_buf_r <= b_buf_r;
            end
            for (int r = 0; r < N; r++) begin
                if (row_r == RW'(r + 1)) begin
                    a_buf_r[r] <= mem_readdata;
                end else begin
                    a_buf_r[r] <= a_buf_r[r];
                end
            end
        end else begin
            b_buf_r <= b_buf_r;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            mac_unit #(
                .DW   (DW),
                .ACCW (ACCW)
            ) u_mac (
                .CLOCK_50 (CLOCK_50),
                .rst_n    (rst_n),
                .en       (en_s),
                .clr      (clr_s),
                .a        (a_elem_s[gi]),
                .b        (b_elem_s),
                .acc      (acc_s[gi])
            );
        end
    endgenerate

    // Registered outputs derived from the next state so they line up with the state register.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_address_r <= '0;
            result_r      <= '0;
        end else begin
            busy_r     <= (state_next_s inside {REQ, WAIT, EXEC});
            done_r     <= (state_next_s == DONE);
            mem_read_r <= (state_next_s == REQ);
            if (state_next_s == REQ) begin
                mem_address_r <= AW'(row_next_s);
            end else begin
                mem_address_r <= mem_address_r;
            end
            if (last_s) begin
                for (int i = 0; i < N; i++) begin
                    result_r[(N-1-i)*ACCW +: ACCW] <= acc_s[i];
                end
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_read    = mem_read_r;
    assign mem_address = mem_address_r;
    assign result      = result_r;

endmodule

// File: doc/matvec_engine.md
Name: matvec_engine

Overview:
Parametrised N×N matrix by N-vector multiply engine with a start/done interface.
- Fetches the vector B and the matrix A, one row per memory word, over a read/readdatavalid memory port.
- Buffers them in internal register arrays.
- Runs N MAC lanes in parallel, so all N dot products finish in N cycles.
- Sits between the board top level and the memory wrapper, replacing the fixed 8-row FIFO/single-MAC datapath.

Parameters:
- N, 8, matrix dimension; also the number of elements per memory word and the number of MAC lanes (N ≥ 2).
- DW, 8, element width in bits, unsigned.
- ACCW, 24, accumulator/result width in bits.
- AW, 32, memory address width.

Ports:
- CLOCK_50  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin; sampled only in IDLE.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high while in DONE (sticky until the next start).
- mem_address  out  AW  word address of the row being fetched.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  memory not accepting the request.
- mem_readdata  in  N*DW  one row; element 0 is in the MSBs.
- mem_readdatavalid  in  1  mem_readdata valid this cycle.
- result  out  N*ACCW  C[i] = sum over k of A[i][k]*B[k]; C[0] is in the MSBs.

Behaviour:
- Reset: state IDLE; busy=0, done=0, mem_read=0, mem_address=0, result=0; row counter, column counter, A/B buffers and accumulators all 0. Reset asserted in any state, including mid-fetch or mid-EXEC, aborts the run immediately.
- Memory map: address 0 holds B. Address r (1..N) holds A row r-1.
- FSM states: IDLE, REQ, WAIT, EXEC, DONE.
- IDLE: start=1 → REQ. Set row=0 and clear all accumulators.
- REQ: mem_read=1 and mem_address=row. Both are held stable while mem_waitrequest=1. When mem_waitrequest=0, the request is accepted → WAIT.
- WAIT: mem_read=0. On mem_readdatavalid, capture the word: row 0 goes to B, row r goes to A[r-1]. Then:
  - if row==N → EXEC with col=0;
  - else row+1 → REQ.
- readdatavalid outside WAIT is ignored.
- EXEC: every lane i computes acc[i] += A[i][col]*B[col]. The product is DW×DW → 2DW bits, zero-extended or truncated to ACCW. The sum wraps modulo 2^ACCW; there is no saturation. col increments each cycle. At col==N-1, register acc into result → DONE.
- DONE: done=1 and result is stable. start=1 → REQ, with accumulators cleared and row=0; result holds its old value until the new run's EXEC completes. start is ignored while busy.
- Latency: start is sampled in cycle 0. With waitrequest=0 and readdatavalid arriving L≥1 cycles after acceptance:
  - each row takes L+1 cycles;
  - the last row is captured at cycle (N+1)(L+1);
  - EXEC occupies the next N cycles;
  - done first rises at cycle (N+1)(L+1)+N+1.
- Each cycle of waitrequest stall adds one cycle.

Decomposition:
- Package matvec_pkg holds:
  - the state_t enum {IDLE, REQ, WAIT, EXEC, DONE};
  - the default constants for N, DW, ACCW.
- Sub-module mac_unit #(DW, ACCW): ports CLOCK_50, rst_n, en, clr, a, b, acc. Instantiated N times in a generate loop.
- Top level contains the FSM, the row/col counters and the A/B register arrays.

Test Plan:
- N=8, L=1: B=1..8, A=identity → result C[i]=i+1; done at cycle 9*2+9=27; busy high cycles 1–26.
- N=8: all A and B elements 255 → every C[i]=520200. Same data with ACCW=16 → every C[i]=61448 (wrap).
- waitrequest held high 3 cycles on the row-4 request → mem_address=4 and mem_read=1 stay stable; done is delayed by exactly 3 cycles; results are unchanged.
- rst_n pulsed low in EXEC at col=3 → outputs 0 and state IDLE immediately. A fresh start gives correct results with no residue from the aborted run.
- Back-to-back runs: start in DONE with a new B=all 2 and A=all 1 → C[i]=16 (no accumulation from run 1). start pulsed during WAIT is ignored.
- Spurious readdatavalid in IDLE or REQ → no buffer change; checked by comparing against the expected C.
